// File: rtl/syn_pkg.sv
// Shared definitions for the seconds-sync link: receiver state encoding,
// default slot timing and the frame slot map used by transmitter and receiver.
package syn_pkg;

    localparam int SYN_BIT_CLKS  = 5;
    localparam int SYN_DATA_BITS = 8;
    localparam int SYN_CNT_W     = 16;

    typedef logic [2:0] syn_state_t;

    localparam syn_state_t ST_ARM   = 3'd0;
    localparam syn_state_t ST_IDLE  = 3'd1;
    localparam syn_state_t ST_START = 3'd2;
    localparam syn_state_t ST_DATA  = 3'd3;
    localparam syn_state_t ST_STOP  = 3'd4;

    // Slot positions within one frame, counted from the start slot.
    localparam int SLOT_START      = 0;
    localparam int SLOT_DATA_FIRST = 1;
    localparam int SLOT_DATA_LAST  = SLOT_DATA_FIRST + SYN_DATA_BITS - 1;
    localparam int SLOT_STOP       = SLOT_DATA_LAST + 1;

endpackage

// File: rtl/syn_rx_if.sv
// Receiver-facing bundle: serial line in, recovered seconds byte and status out.
// The master modport is the side that drives the line and observes the results.
interface syn_rx_if #(
    parameter int DATA_BITS = syn_pkg::SYN_DATA_BITS
);
    logic                          rx_in;
    logic [DATA_BITS-1:0]          second_out;
    logic                          sec_valid;
    logic                          frame_err;
    logic                          busy;
    logic [syn_pkg::SYN_CNT_W-1:0] good_cnt;

    modport master (
        output rx_in,
        input  second_out,
        input  sec_valid,
        input  frame_err,
        input  busy,
        input  good_cnt
    );

    modport slave (
        input  rx_in,
        output second_out,
        output sec_valid,
        output frame_err,
        output busy,
        output good_cnt
    );
endinterface

// File: rtl/syn_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, plus a registered
// copy of the synchronized level so a 0->1 transition can be detected.
module syn_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rise_o
);
    logic ff1_q;
    logic ff2_q;
    logic rx_d_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ff1_q  <= 1'b0;
            ff2_q  <= 1'b0;
            rx_d_q <= 1'b0;
        end else begin
            ff1_q  <= rx_i;
            ff2_q  <= ff1_q;
            rx_d_q <= ff2_q;
        end
    end

    assign rx_s_o = ff2_q;
    assign rise_o = ff2_q & ~rx_d_q;
endmodule

// File: rtl/syn_rx.sv
// Slave-side receiver for the seconds-sync frame (start 1, data MSB first, stop 0).
// Recovers the byte with a one-cycle strobe, flags bad stop slots, counts good frames.
module syn_rx
    import syn_pkg::*;
#(
    parameter int BIT_CLKS  = SYN_BIT_CLKS,
    parameter int DATA_BITS = SYN_DATA_BITS
) (
    input  logic    clk_10M,
    input  logic    rst_n,
    syn_rx_if.slave syn_bus
);
    localparam int HALF  = BIT_CLKS / 2;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [7:0]       CNT_LAST = 8'(BIT_CLKS - 1);
    localparam logic [7:0]       CNT_HALF = 8'(HALF - 1);
    localparam logic [7:0]       CNT_ONE  = 8'd1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic rx_s;
    logic rise;

    syn_rx_sync u_sync (
        .clk_i  (clk_10M),
        .rst_ni (rst_n),
        .rx_i   (syn_bus.rx_in),
        .rx_s_o (rx_s),
        .rise_o (rise)
    );

    syn_state_t             state_q,     state_d;
    logic [7:0]             cnt_q,       cnt_d;
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [DATA_BITS-1:0]   sh_q,        sh_d;
    logic [DATA_BITS-1:0]   sec_out_q,   sec_out_d;
    logic                   sec_valid_q, sec_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [SYN_CNT_W-1:0]   good_cnt_q,  good_cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        sec_out_d   = sec_out_q;
        sec_valid_d = 1'b0;
        frame_err_d = 1'b0;
        good_cnt_d  = good_cnt_q;

        case (state_q)
            // ARM demands a full slot of quiet line so a stuck-high or mid-frame
            // line after reset or an error cannot be mistaken for a start edge.
            ST_ARM: begin
                if (rx_s) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    cnt_d   = 8'd0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = 8'd0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_DATA : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Sampling point stays at slot centre because START ended half a slot in.
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 8'd0;
                    sh_d  = {sh_q[DATA_BITS-2:0], rx_s};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 8'd0;
                    if (!rx_s) begin
                        sec_out_d   = sh_q;
                        sec_valid_d = 1'b1;
                        good_cnt_d  = good_cnt_q + 16'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_ARM;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_ARM;
            end
        endcase
    end

    always_ff @(posedge clk_10M) begin
        if (!rst_n) begin
            state_q     <= ST_ARM;
            cnt_q       <= 8'd0;
            idx_q       <= '0;
            sh_q        <= '0;
            sec_out_q   <= '0;
            sec_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            good_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            sec_out_q   <= sec_out_d;
            sec_valid_q <= sec_valid_d;
            frame_err_q <= frame_err_d;
            good_cnt_q  <= good_cnt_d;
        end
    end

    assign syn_bus.second_out = sec_out_q;
    assign syn_bus.sec_valid  = sec_valid_q;
    assign syn_bus.frame_err  = frame_err_q;
    assign syn_bus.good_cnt   = good_cnt_q;
    assign syn_bus.busy       = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
endmodule

// File: tb/tb_syn_rx.sv
`timescale 1ns/1ps
// Bench for syn_rx: frames are scheduled as expected events from the slot timing,
// then directed scenarios and a randomized mix are compared cycle by cycle.
module tb_syn_rx;
    import syn_pkg::*;

    localparam int B   = SYN_BIT_CLKS;
    localparam int H   = B / 2;
    localparam int LAT = 2 + H + SLOT_STOP * B;

    typedef struct { int cyc; bit err; logic [7:0] data; } ev_t;
    typedef struct { int lo; int hi; } iv_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    syn_rx_if #(.DATA_BITS(8)) bus ();

    syn_rx #(.BIT_CLKS(B), .DATA_BITS(8)) dut (
        .clk_10M (clk),
        .rst_n   (rst_n),
        .syn_bus (bus)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t        evq[$];
    iv_t        bq[$];
    logic [7:0] m_sec = 8'h00;
    logic [15:0] m_cnt = 16'h0000;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         last_valid_cyc = -1;
    int         busy_run = 0;
    int         max_busy_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the event-level model.
    always @(posedge clk) begin
        bit e_v;
        bit e_e;
        bit e_b;
        #1;
        if (chk_en) begin
            e_v = 1'b0;
            e_e = 1'b0;
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                chk("missed_event", 32'(cyc), 32'(evq[0].cyc));
                evq.delete(0);
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                if (evq[0].err) begin
                    e_e = 1'b1;
                end else begin
                    e_v   = 1'b1;
                    m_sec = evq[0].data;
                    m_cnt = m_cnt + 16'd1;
                end
                evq.delete(0);
            end
            while (bq.size() > 0 && bq[0].hi < cyc) bq.delete(0);
            e_b = (bq.size() > 0) && (bq[0].lo <= cyc);

            chk("sec_valid",  32'(bus.sec_valid),  32'(e_v));
            chk("frame_err",  32'(bus.frame_err),  32'(e_e));
            chk("busy",       32'(bus.busy),       32'(e_b));
            chk("second_out", 32'(bus.second_out), 32'(m_sec));
            chk("good_cnt",   32'(bus.good_cnt),   32'(m_cnt));

            if (bus.sec_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (bus.frame_err) n_err++;
            if (bus.busy) busy_run++;
            else busy_run = 0;
            if (busy_run > max_busy_run) max_busy_run = busy_run;
        end
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx_in = v;
        end
    endtask

    // Sends start slot plus the first nbits data bits; the stop slot only for full frames.
    task automatic send_frame(input logic [7:0] d, input bit bad, input int extra,
                              input int nbits, output int t0);
        @(negedge clk);
        bus.rx_in = 1'b1;
        t0 = cyc + 1;
        evq.push_back('{t0 + LAT, bad, d});
        bq.push_back('{t0 + 2, t0 + LAT - 1});
        drive(1'b1, B - 1);
        for (int k = 7; k >= 8 - nbits; k--) drive(d[k], B);
        if (nbits == 8) drive(logic'(bad), B + (bad ? extra : 0));
    endtask

    task automatic glitch(input int g, output int t0);
        @(negedge clk);
        bus.rx_in = 1'b1;
        t0 = cyc + 1;
        bq.push_back('{t0 + 2, t0 + 1 + H});
        drive(1'b1, g - 1);
        drive(1'b0, B);
    endtask

    task automatic pulse_reset(input int n, input logic line);
        int   r;
        ev_t  keep_ev[$];
        iv_t  keep_iv[$];
        @(negedge clk);
        rst_n     = 1'b0;
        bus.rx_in = line;
        r = cyc + 1;
        foreach (evq[i]) if (evq[i].cyc < r) keep_ev.push_back(evq[i]);
        evq = keep_ev;
        foreach (bq[i]) begin
            if (bq[i].lo < r) keep_iv.push_back('{bq[i].lo, (bq[i].hi < r) ? bq[i].hi : r - 1});
        end
        bq    = keep_iv;
        m_sec = 8'h00;
        m_cnt = 16'h0000;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #6000000;
        $display("FAIL watchdog at cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int nv;
        int ne;
        rst_n     = 1'b0;
        bus.rx_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_second_out", 32'(bus.second_out), 32'h00);
        chk("rst_sec_valid",  32'(bus.sec_valid),  32'h0);
        chk("rst_frame_err",  32'(bus.frame_err),  32'h0);
        chk("rst_busy",       32'(bus.busy),       32'h0);
        chk("rst_good_cnt",   32'(bus.good_cnt),   32'h0000);
        rst_n = 1'b1;

        // T1: single frame after a quiet line
        drive(1'b0, 10);
        send_frame(8'h3C, 1'b0, 0, 8, t0);
        drive(1'b0, B);
        chk("t1_latency",  32'(last_valid_cyc - t0), 32'd49);
        chk("t1_data",     32'(bus.second_out),      32'h3C);
        chk("t1_good_cnt", 32'(bus.good_cnt),        32'd1);
        chk("t1_no_err",   32'(n_err),               32'd0);

        // T2: back-to-back frames separated by one idle slot
        send_frame(8'h00, 1'b0, 0, 8, t0);
        drive(1'b0, B);
        chk("t2_data0", 32'(bus.second_out), 32'h00);
        chk("t2_cnt0",  32'(bus.good_cnt),   32'd2);
        send_frame(8'hFF, 1'b0, 0, 8, t0);
        drive(1'b0, B);
        chk("t2_data1",  32'(bus.second_out), 32'hFF);
        chk("t2_cnt1",   32'(bus.good_cnt),   32'd3);
        chk("t2_nvalid", 32'(n_valid),        32'd3);

        // T3: short high pulse is rejected at the start-slot sample
        nv = n_valid;
        ne = n_err;
        max_busy_run = 0;
        glitch(2, t0);
        chk("t3_no_valid", 32'(n_valid),      32'(nv));
        chk("t3_no_err",   32'(n_err),        32'(ne));
        chk("t3_busy_len", 32'(max_busy_run), 32'd2);
        chk("t3_idle",     32'(bus.busy),     32'h0);

        // T4: bad stop slot, then recovery after a quiet slot
        ne = n_err;
        send_frame(8'hA5, 1'b1, 3, 8, t0);
        chk("t4_err",  32'(n_err),          32'(ne + 1));
        chk("t4_keep", 32'(bus.second_out), 32'hFF);
        chk("t4_cnt",  32'(bus.good_cnt),   32'd3);
        drive(1'b0, 5);
        send_frame(8'h11, 1'b0, 0, 8, t0);
        drive(1'b0, B);
        chk("t4_data", 32'(bus.second_out), 32'h11);
        chk("t4_cnt2", 32'(bus.good_cnt),   32'd4);

        // T5: reset in the middle of the data slots
        send_frame(8'h5A, 1'b0, 0, 3, t0);
        pulse_reset(3, 1'b1);
        chk("t5_rst_data", 32'(bus.second_out), 32'h00);
        chk("t5_rst_cnt",  32'(bus.good_cnt),   32'h0000);
        chk("t5_rst_busy", 32'(bus.busy),       32'h0);
        nv = n_valid;
        drive(1'b1, 6);
        drive(1'b0, B);
        chk("t5_no_valid", 32'(n_valid), 32'(nv));
        send_frame(8'h7E, 1'b0, 0, 8, t0);
        drive(1'b0, B);
        chk("t5_data", 32'(bus.second_out), 32'h7E);
        chk("t5_cnt",  32'(bus.good_cnt),   32'd1);

        // T6: counter wrap from a preloaded value
        @(negedge clk);
        force dut.good_cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.good_cnt_q;
        @(negedge clk);
        chk("t6_preload", 32'(bus.good_cnt), 32'hFFFE);
        send_frame(8'h01, 1'b0, 0, 8, t0);
        drive(1'b0, B);
        chk("t6_full", 32'(bus.good_cnt), 32'hFFFF);
        send_frame(8'h02, 1'b0, 0, 8, t0);
        drive(1'b0, B);
        chk("t6_wrap", 32'(bus.good_cnt),   32'h0000);
        chk("t6_data", 32'(bus.second_out), 32'h02);

        // Randomized mix of good, bad, glitch and reset-aborted frames
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                send_frame(8'($urandom), 1'b0, 0, 8, t0);
                drive(1'b0, $urandom_range(B, 3 * B));
            end else if (kind <= 7) begin
                send_frame(8'($urandom), 1'b1, $urandom_range(0, B), 8, t0);
                drive(1'b0, $urandom_range(B, 2 * B));
            end else if (kind == 8) begin
                glitch($urandom_range(1, H), t0);
                drive(1'b0, $urandom_range(0, B));
            end else begin
                send_frame(8'($urandom), 1'b0, 0, $urandom_range(0, 7), t0);
                pulse_reset($urandom_range(1, 4), 1'b1);
                drive(1'b1, $urandom_range(1, 4));
                drive(1'b0, $urandom_range(B, 2 * B));
            end
        end

        drive(1'b0, 3 * B);
        chk("pending_events", 32'(evq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
